// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: shared constants for the counter arbiter.
// State encoding, default sizes and the state register width.
package counter_arb_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_CNT_W = 8;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_CLEAR = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Searches from ptr upward (wrapping) and returns the first requester
// found as a one-hot grant, its index and an any-request flag.
module rr_arbiter
    import counter_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan requesters in rotated order; first hit wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = j[IDX_W-1:0];
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one counter among N_REQ requesters.
// Each grant clears the counter, drives valid for exactly req_len cycles,
// then pulses done to the winner. Optional watchdog abort is enabled by
// defining COUNTER_ARB_TIMEOUT_EN (adds the err port).
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_len,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   cnt_rst,
    output logic                   cnt_valid,
    input  logic [CNT_W-1:0]       cnt_count
`ifdef COUNTER_ARB_TIMEOUT_EN
    ,
    output logic [N_REQ-1:0]       err
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [STATE_W-1:0] state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   gidx_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [CNT_W-1:0]   tgt_reg;

    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               run_hit;
    logic               wd_expire;
    logic               aborted;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign run_hit = (cnt_count == tgt_reg);

`ifdef COUNTER_ARB_TIMEOUT_EN
    logic [CNT_W:0] wd_reg;
    logic [CNT_W:0] wd_limit;
    logic           abort_reg;

    assign wd_limit  = {1'b0, tgt_reg} + (CNT_W+1)'(TIMEOUT);
    // Expire on the RUN cycle that brings the watchdog to tgt+TIMEOUT.
    assign wd_expire = (state_reg == ST_RUN) && !run_hit &&
                       ((wd_reg + (CNT_W+1)'(1)) == wd_limit);
    assign aborted   = abort_reg;

    // Watchdog: cleared per transaction, counts RUN cycles, remembers an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_reg    <= '0;
            abort_reg <= 1'b0;
        end else if (state_reg == ST_CLEAR) begin
            wd_reg    <= '0;
            abort_reg <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            wd_reg <= wd_reg + (CNT_W+1)'(1);
            if (wd_expire) begin
                abort_reg <= 1'b1;
            end
        end
    end

    assign err = (!rst && state_reg == ST_DONE && abort_reg) ? gnt_reg : '0;
`else
    assign wd_expire = 1'b0;
    assign aborted   = 1'b0;
`endif

    // Next-state decode for the IDLE/CLEAR/RUN/DONE sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (arb_any) state_next = ST_CLEAR;
            ST_CLEAR: state_next = (tgt_reg == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (run_hit || wd_expire) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, grant latch, run target and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            gidx_reg  <= '0;
            gnt_reg   <= '0;
            tgt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && arb_any) begin
                gnt_reg  <= arb_grant;
                gidx_reg <= arb_idx;
                tgt_reg  <= req_len[arb_idx*CNT_W +: CNT_W];
            end
            if (state_reg == ST_DONE) begin
                gnt_reg <= '0;
                ptr_reg <= (gidx_reg == IDX_W'(N_REQ-1)) ? '0 : gidx_reg + IDX_W'(1);
            end
        end
    end

    assign gnt       = gnt_reg;
    assign cnt_rst   = rst | (state_reg == ST_CLEAR);
    // Valid drops combinationally the cycle the count matches, so no overshoot.
    assign cnt_valid = !rst && (state_reg == ST_RUN) && !run_hit && !wd_expire;
    assign done      = (!rst && state_reg == ST_DONE && !aborted) ? gnt_reg : '0;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed test of counter_arbiter driving a
// behavioural 8-bit counter. Define COUNTER_ARB_TIMEOUT_EN to add the
// watchdog abort step.
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_len;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           cnt_rst;
    logic           cnt_valid;
    logic [W-1:0]   cnt_count;
`ifdef COUNTER_ARB_TIMEOUT_EN
    logic [N-1:0]   err;
`endif

    int tests;
    int fails;
    logic stuck;

    counter_arbiter #(.N_REQ(N), .CNT_W(W), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .done      (done),
        .cnt_rst   (cnt_rst),
        .cnt_valid (cnt_valid),
        .cnt_count (cnt_count)
`ifdef COUNTER_ARB_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared counter being arbitrated; stuck freezes it for the watchdog step.
    always @(posedge clk) begin
        if (cnt_rst) cnt_count <= '0;
        else if (cnt_valid && !stuck) cnt_count <= cnt_count + 8'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called in the IDLE cycle where req is sampled (cycle 0); returns in the
    // IDLE cycle following DONE.
    task automatic run_txn(input logic [N-1:0] eg, input int len, input string tag);
        int vcnt;
        int dcyc;
        int ecyc;
        vcnt = 0;
        dcyc = -1;
        ecyc = (len == 0) ? 2 : len + 3;
        step();
        chk(32'(gnt), 32'(eg), {tag, " gnt@1"});
        chk(32'(cnt_rst), 32'd1, {tag, " clear@1"});
        for (int cyc = 2; cyc <= 300 && dcyc < 0; cyc++) begin
            step();
            if (cnt_valid) vcnt++;
            if (done != '0) begin
                dcyc = cyc;
                chk(32'(done), 32'(eg), {tag, " done vec"});
                chk(32'(cnt_count), 32'(len), {tag, " count"});
            end
        end
        chk(32'(dcyc), 32'(ecyc), {tag, " done cycle"});
        chk(32'(vcnt), 32'(len), {tag, " valid cycles"});
        step();
        chk(32'(done), 32'd0, {tag, " done one-shot"});
        chk(32'(gnt), 32'd0, {tag, " gnt released"});
        $display("[TB] txn %s: gnt=%b len=%0d done_cycle=%0d valid=%0d count=%0d",
                 tag, eg, len, dcyc, vcnt, cnt_count);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        stuck   = 1'b0;
        rst     = 1'b1;
        req     = '0;
        req_len = '0;
        step();
        step();
        chk(32'(gnt), 32'd0, "reset gnt");
        chk(32'(done), 32'd0, "reset done");
        chk(32'(cnt_valid), 32'd0, "reset valid");
        chk(32'(cnt_rst), 32'd1, "reset cnt_rst");
        chk(32'(cnt_count), 32'd0, "reset count");
        rst = 1'b0;
        step();
        chk(32'(cnt_rst), 32'd0, "idle cnt_rst");

        // Single requester, len 5.
        req = 4'b0001;
        req_len[0*W +: W] = 8'd5;
        run_txn(4'b0001, 5, "single");
        req = '0;

        // Zero-length run on requester 2.
        req = 4'b0100;
        req_len[2*W +: W] = 8'd0;
        run_txn(4'b0100, 0, "zero_len");
        req = '0;
        step();

        // Reset mid-RUN at count 4 of 10 on requester 3.
        req = 4'b1000;
        req_len[3*W +: W] = 8'd10;
        step();
        chk(32'(gnt), 32'b1000, "midrst gnt");
        for (int k = 0; k < 5; k++) step();
        chk(32'(cnt_count), 32'd4, "midrst count before");
        rst = 1'b1;
        #1;
        chk(32'(cnt_rst), 32'd1, "midrst cnt_rst");
        step();
        chk(32'(gnt), 32'd0, "midrst gnt after");
        chk(32'(cnt_valid), 32'd0, "midrst valid after");
        chk(32'(done), 32'd0, "midrst no done");
        chk(32'(cnt_count), 32'd0, "midrst count after");
        rst = 1'b0;
        $display("[TB] txn midrst: aborted at count 4, counter cleared");

        // All four requesting, len 3 each; pointer restarts at 0 after reset.
        for (int i = 0; i < N; i++) req_len[i*W +: W] = 8'd3;
        req = 4'b1111;
        run_txn(4'b0001, 3, "rr0");
        run_txn(4'b0010, 3, "rr1");
        run_txn(4'b0100, 3, "rr2");
        run_txn(4'b1000, 3, "rr3");
        run_txn(4'b0001, 3, "rr0b");
        req = '0;
        step();

        // Maximum length on requester 1.
        req = 4'b0010;
        req_len[1*W +: W] = 8'd255;
        run_txn(4'b0010, 255, "max_len");
        req = '0;
        step();

`ifdef COUNTER_ARB_TIMEOUT_EN
        // Stuck counter: watchdog aborts after 26 RUN cycles, err at cycle 28.
        begin
            int ecyc;
            int dseen;
            ecyc  = -1;
            dseen = 0;
            stuck = 1'b1;
            req   = 4'b0001;
            req_len[0*W +: W] = 8'd10;
            step();
            chk(32'(gnt), 32'b0001, "wd gnt");
            req = '0;
            for (int cyc = 2; cyc <= 60 && ecyc < 0; cyc++) begin
                step();
                if (done != '0) dseen++;
                if (err != '0) begin
                    ecyc = cyc;
                    chk(32'(err), 32'b0001, "wd err vec");
                end
            end
            chk(32'(ecyc), 32'd28, "wd err cycle");
            chk(32'(dseen), 32'd0, "wd no done");
            step();
            chk(32'(err), 32'd0, "wd err one-shot");
            chk(32'(gnt), 32'd0, "wd back idle");
            stuck = 1'b0;
            $display("[TB] txn watchdog: err_cycle=%0d", ecyc);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
